// File: rtl/mem_iface_pkg.sv
// mem_iface_pkg: shared state encoding and default sizing for the memory interface.
package mem_iface_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_MAX_WAIT = 15;
endpackage

// File: rtl/mem_iface.sv
// mem_iface: MAR/MDR/read-buffer datapath with a request/ack handshake to external memory.
module mem_iface
    import mem_iface_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MARWr,
    input  logic             MDRWr,
    input  logic             MDRSrc,
    input  logic             MDROe,
    input  logic             MemRd,
    input  logic             MemWr,
    input  logic             MemOe,
    input  logic [WIDTH-1:0] BusIn,
    output logic [WIDTH-1:0] BusOut,
    output logic             BusOutEn,
    output logic             Busy,
    output logic             Err,
    output logic [WIDTH-1:0] MemAddr,
    output logic [WIDTH-1:0] MemWData,
    input  logic [WIDTH-1:0] MemRData,
    output logic             MemReq,
    output logic             MemWe,
    input  logic             MemAck
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t state, state_n;
    logic [WIDTH-1:0] mar, mdr, rdbuf;
    logic [CW-1:0] cnt;
    logic we, req, legal, start, done, timeout;

    always_comb begin
        req     = (state == IDLE) && (MemRd || MemWr);
        legal   = (MemRd ^ MemWr) && (mar[1:0] == 2'b00);
        start   = req && legal;
        done    = (state == BUSY) && MemAck;
        timeout = (state == BUSY) && !MemAck && (cnt == CW'(MAX_WAIT - 1));
        state_n = (state == IDLE) ? (start ? BUSY : IDLE) :
                  (state == BUSY) ? (done ? IDLE : timeout ? ABORT : BUSY) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mar   <= '0;
            mdr   <= '0;
            rdbuf <= '0;
            cnt   <= '0;
            we    <= 1'b0;
            Err   <= 1'b0;
        end else begin
            if (MARWr) mar <= BusIn;
            // MDR takes the pre-edge read buffer even when a read completes this cycle
            if (MDRWr) mdr <= MDRSrc ? rdbuf : BusIn;
            if (done && !we) rdbuf <= MemRData;
            if (start) we <= MemWr;
            if (start) cnt <= '0;
            else if (state == BUSY && !MemAck) cnt <= cnt + 1'b1;
            Err <= Err | (req && !legal) | timeout | (MDROe && MemOe);
        end
    end

    assign Busy     = (state != IDLE);
    assign MemReq   = (state == BUSY);
    assign MemWe    = we;
    assign MemAddr  = mar;
    assign MemWData = mdr;
    assign BusOutEn = MDROe | MemOe;
    assign BusOut   = MDROe ? mdr : MemOe ? rdbuf : '0;
endmodule

// File: tb/tb_mem_iface.sv
// tb_mem_iface: directed checks of the memory interface handshake, abort and error paths.
module tb_mem_iface;
    logic        clk = 1'b0, rst = 1'b1;
    logic        MARWr = 0, MDRWr = 0, MDRSrc = 0, MDROe = 0, MemRd = 0, MemWr = 0, MemOe = 0, MemAck = 0;
    logic [31:0] BusIn = '0, MemRData = '0;
    logic [31:0] BusOut, MemAddr, MemWData;
    logic        BusOutEn, Busy, Err, MemReq, MemWe;
    int          n_tests = 0, n_fail = 0;

    mem_iface dut (
        .clk(clk), .rst(rst), .MARWr(MARWr), .MDRWr(MDRWr), .MDRSrc(MDRSrc), .MDROe(MDROe),
        .MemRd(MemRd), .MemWr(MemWr), .MemOe(MemOe), .BusIn(BusIn), .BusOut(BusOut),
        .BusOutEn(BusOutEn), .Busy(Busy), .Err(Err), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData), .MemReq(MemReq), .MemWe(MemWe), .MemAck(MemAck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_mar(input logic [31:0] v);
        MARWr = 1; BusIn = v; tick; MARWr = 0;
    endtask

    task automatic pulse_rst;
        #2 rst = 1;
        #1 rst = 0;
    endtask

    initial begin
        #2;
        chk("rst_busy", Busy, 0);
        chk("rst_req", MemReq, 0);
        chk("rst_err", Err, 0);
        chk("rst_addr", MemAddr, 0);
        chk("rst_wdata", MemWData, 0);
        chk("rst_busouten", BusOutEn, 0);
        tick; tick;
        rst = 0;

        // read, ack on third BUSY cycle
        load_mar(32'h10);
        chk("rd_addr", MemAddr, 32'h10);
        MemRd = 1; tick; MemRd = 0;
        chk("rd_req1", MemReq, 1);
        chk("rd_we", MemWe, 0);
        chk("rd_busy1", Busy, 1);
        tick;
        chk("rd_req2", MemReq, 1);
        tick;
        chk("rd_req3", MemReq, 1);
        MemAck = 1; MemRData = 32'hDEADBEEF; tick; MemAck = 0;
        chk("rd_req_done", MemReq, 0);
        chk("rd_busy_done", Busy, 0);
        MemOe = 1; #1;
        chk("rd_busout", BusOut, 32'hDEADBEEF);
        chk("rd_busouten", BusOutEn, 1);
        MemOe = 0;

        // write, ack on first BUSY cycle
        MDRWr = 1; MDRSrc = 0; BusIn = 32'h12345678; tick; MDRWr = 0;
        load_mar(32'h20);
        MemWr = 1; tick; MemWr = 0;
        chk("wr_req", MemReq, 1);
        chk("wr_we", MemWe, 1);
        chk("wr_addr", MemAddr, 32'h20);
        chk("wr_wdata", MemWData, 32'h12345678);
        MemAck = 1; tick; MemAck = 0;
        chk("wr_busy_done", Busy, 0);
        MDROe = 1; #1;
        chk("wr_mdr_out", BusOut, 32'h12345678);
        MDROe = 0;

        // read then write-back of the read data to a new address
        load_mar(32'h30);
        MemRd = 1; tick; MemRd = 0;
        MemAck = 1; MemRData = 32'hCAFEF00D; tick; MemAck = 0;
        chk("wb_busy", Busy, 0);
        MDRWr = 1; MDRSrc = 1; tick; MDRWr = 0; MDRSrc = 0;
        load_mar(32'h40);
        MemWr = 1; tick; MemWr = 0;
        chk("wb_we", MemWe, 1);
        chk("wb_addr", MemAddr, 32'h40);
        chk("wb_wdata", MemWData, 32'hCAFEF00D);
        MemAck = 1; tick; MemAck = 0;
        chk("wb_err", Err, 0);

        // MDR load from RdBuf on the read-ack edge sees the old buffer
        load_mar(32'h50);
        MemRd = 1; tick; MemRd = 0;
        MemAck = 1; MemRData = 32'h11112222; MDRWr = 1; MDRSrc = 1; tick;
        MemAck = 0; MDRWr = 0; MDRSrc = 0;
        chk("same_edge_mdr", MemWData, 32'hCAFEF00D);
        MemOe = 1; #1;
        chk("same_edge_rdbuf", BusOut, 32'h11112222);
        MemOe = 0;

        // timeout abort
        MemRData = 32'hBAD0BAD0;
        MemRd = 1; tick; MemRd = 0;
        begin
            int hi = 0;
            repeat (15) begin
                if (MemReq) hi++;
                tick;
            end
            chk("abort_busy_cycles", hi, 15);
        end
        chk("abort_req", MemReq, 0);
        chk("abort_busy", Busy, 1);
        chk("abort_err", Err, 1);
        tick;
        chk("abort_idle", Busy, 0);
        MemAck = 1; tick; MemAck = 0;
        MemOe = 1; #1;
        chk("abort_rdbuf", BusOut, 32'h11112222);
        MemOe = 0;

        // async reset clears without a clock
        pulse_rst;
        chk("arst_err", Err, 0);
        chk("arst_addr", MemAddr, 0);

        // misaligned address
        load_mar(32'h13);
        MemRd = 1; tick; MemRd = 0;
        chk("misalign_req", MemReq, 0);
        chk("misalign_busy", Busy, 0);
        chk("misalign_err", Err, 1);

        // simultaneous read and write
        pulse_rst;
        load_mar(32'h10);
        MemRd = 1; MemWr = 1; tick; MemRd = 0; MemWr = 0;
        chk("rdwr_req", MemReq, 0);
        chk("rdwr_err", Err, 1);

        // both output enables
        pulse_rst;
        MDRWr = 1; BusIn = 32'hA5A5A5A5; tick; MDRWr = 0;
        chk("oe_err_before", Err, 0);
        MDROe = 1; MemOe = 1; #1;
        chk("oe_priority", BusOut, 32'hA5A5A5A5);
        tick; MDROe = 0; MemOe = 0;
        chk("oe_err", Err, 1);

        // reset during second BUSY cycle, then a late ack
        pulse_rst;
        load_mar(32'h10);
        MemRd = 1; tick; MemRd = 0;
        tick;
        chk("mid_req_pre", MemReq, 1);
        #1 rst = 1; #1;
        chk("mid_req", MemReq, 0);
        chk("mid_busy", Busy, 0);
        chk("mid_addr", MemAddr, 0);
        chk("mid_we", MemWe, 0);
        tick; rst = 0;
        MemAck = 1; MemRData = 32'h55555555; tick; MemAck = 0;
        chk("late_ack_busy", Busy, 0);
        chk("late_ack_req", MemReq, 0);
        chk("late_ack_err", Err, 0);
        MemOe = 1; #1;
        chk("late_ack_rdbuf", BusOut, 0);
        MemOe = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
